mms_frame_tracker: RTL and testbench

- Streaming front-end for the max/min selector family.
- Accepts 8-bit numbers one per beat over a valid/ready handshake, groups them into fixed-length frames, and tracks the running maximum or minimum plus the position where it occurred.
- At frame end, presents one result word downstream and holds it until consumed.
- Replaces the fixed four-input parallel comparison tree wherever operands arrive serially.

---
 rtl/mms_frame_tracker.sv | 126 ++++++++++++
 tb/tb_mms_frame_tracker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mms_frame_tracker.sv
// mms_frame_tracker
//   Serial front-end for the max/min selector family. Accepts one unsigned
//   operand per beat over valid/ready, groups FRAME_LEN beats into a frame,
//   and tracks the running maximum (select=1) or minimum (select=0) together
//   with the 0-based beat position where it first occurred. The finished
//   result is held on result/result_idx with out_valid until out_ready.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   select      1 = max, 0 = min; sampled on the first beat of a frame
//   in_valid    in_data valid
//   in_data     operand (DATA_W)
//   in_ready    beat can be accepted (IDLE/ACC)
//   out_valid   result/result_idx hold a completed frame
//   out_ready   downstream consumes the result
//   result      frame max/min (DATA_W)
//   result_idx  position of result within the frame (IDX_W)
//   busy        frame partially accumulated
module mms_frame_tracker #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              select,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [IDX_W-1:0]  result_idx,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    // Position of the final beat; count_q equals this when the last beat arrives.
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic              sel_q, sel_d;
    logic              ov_q, ov_d;

    logic beat;
    logic better;

    // in_ready depends on state alone so it can never loop back through in_valid.
    assign in_ready = (state_q != HOLD);
    assign beat     = in_valid && in_ready;
    // Strict compare: ties keep the earlier position.
    assign better   = sel_q ? (in_data > best_q) : (in_data < best_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            best_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            sel_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            sel_q   <= sel_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        best_d  = best_q;
        idx_d   = idx_q;
        count_d = count_q;
        sel_d   = sel_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE: begin
                if (beat) begin
                    best_d  = in_data;
                    idx_d   = '0;
                    count_d = IDX_W'(1);
                    sel_d   = select;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    if (better) begin
                        best_d = in_data;
                        idx_d  = count_q;
                    end
                    count_d = count_q + IDX_W'(1);
                    if (count_q == LAST) begin
                        count_d = '0;
                        ov_d    = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid  = ov_q;
    assign result     = best_q;
    assign result_idx = idx_q;
    assign busy       = (state_q == ACC);

endmodule

// File: tb/tb_mms_frame_tracker.sv
module tb_mms_frame_tracker;

    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = 8;
    localparam int IDX_W     = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              select;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic [IDX_W-1:0]  result_idx;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // Expected {result, result_idx} per frame, in completion order.
    logic [DATA_W+IDX_W-1:0] sb_q[$];
    int                      hs_q[$];

    mms_frame_tracker #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .select(select),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_idx(result_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    // One clock: check for an output handshake at the falling edge, then
    // return just after the next rising edge.
    task automatic cyc();
        logic [DATA_W+IDX_W-1:0] exp_v;
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got result=%0d idx=%0d, required no output", result, result_idx);
            end else begin
                exp_v = sb_q.pop_front();
                hs_q.push_back(cyc_n);
                if ({result, result_idx} !== exp_v) begin
                    bad++;
                    $display("FAIL sb_result: got result=%0d idx=%0d, required result=%0d idx=%0d",
                             result, result_idx, exp_v[DATA_W+IDX_W-1:IDX_W], exp_v[IDX_W-1:0]);
                end
            end
        end
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic s);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        select   = s;
        while (!in_ready && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%0d, required 1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            cyc();
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk(input string name, input int got, input int req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_idx", result_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        // Beats offered while reset is high must be ignored.
        in_valid = 1'b1; in_data = 8'd99;
        cyc(); cyc();
        chk("rst_ignore_busy", busy, 0);
        chk("rst_ignore_result", result, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_max();
        logic [7:0] d[8] = '{3, 9, 200, 7, 200, 1, 0, 45};
        sb_q.push_back({8'd200, 3'd2});
        for (int i = 0; i < 8; i++) begin
            send_beat(d[i], 1'b1);
            if (i == 0) chk("max_busy_after_first", busy, 1);
        end
        chk("max_latency_out_valid", out_valid, 1);
        chk("max_in_ready_hold", in_ready, 0);
        wait_drain();
        chk("max_out_valid_drop", out_valid, 0);
    endtask

    task automatic test_min_select();
        logic [7:0] d[8] = '{50, 40, 40, 255, 10, 10, 99, 12};
        sb_q.push_back({8'd10, 3'd4});
        for (int i = 0; i < 8; i++) send_beat(d[i], (i >= 3));
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] d[8] = '{10, 20, 30, 40, 50, 60, 70, 5};
        out_ready = 1'b0;
        sb_q.push_back({8'd70, 3'd6});
        for (int i = 0; i < 8; i++) send_beat(d[i], 1'b1);
        in_valid = 1'b1; in_data = 8'd77; select = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 70);
            chk("bp_idx", result_idx, 6);
            cyc();
        end
        out_ready = 1'b1;
        cyc();                                   // handshake edge
        chk("bp_out_valid_drop", out_valid, 0);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_no_early_accept", busy, 0);
        sb_q.push_back({8'd77, 3'd0});
        cyc();                                   // 77 accepted as beat 0
        in_valid = 1'b0;
        chk("bp_77_accepted", busy, 1);
        for (int i = 1; i < 8; i++) send_beat(i[7:0], 1'b0);
        wait_drain();
    endtask

    task automatic test_stall();
        sb_q.push_back({8'd8, 3'd7});
        for (int i = 1; i <= 8; i++) begin
            send_beat(i[7:0], 1'b1);
            if (i < 8) begin
                for (int g = 0; g < 3; g++) begin
                    chk("stall_busy", busy, 1);
                    cyc();
                end
            end
        end
        wait_drain();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] a[5] = '{1, 2, 250, 3, 4};
        logic [7:0] b[8] = '{5, 6, 7, 8, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) send_beat(a[i], 1'b1);
        reset = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_result", result, 0);
        chk("mrst_idx", result_idx, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        cyc();
        reset = 1'b0;
        sb_q.push_back({8'd8, 3'd3});
        for (int i = 0; i < 8; i++) send_beat(b[i], 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] a[8] = '{9, 8, 7, 6, 5, 4, 3, 2};
        logic [7:0] b[8] = '{0, 255, 0, 1, 2, 3, 4, 5};
        hs_q.delete();
        sb_q.push_back({8'd2, 3'd7});
        sb_q.push_back({8'd0, 3'd0});
        for (int i = 0; i < 8; i++) send_beat(a[i], 1'b0);
        for (int i = 0; i < 8; i++) send_beat(b[i], 1'b0);
        wait_drain();
        total++;
        if (hs_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_handshakes: got %0d, required 2", hs_q.size());
        end else if (hs_q[1] - hs_q[0] != FRAME_LEN + 1) begin
            bad++;
            $display("FAIL b2b_period: got %0d cycles, required %0d", hs_q[1] - hs_q[0], FRAME_LEN + 1);
        end
    endtask

    initial begin
        reset = 1'b1; select = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        test_reset();
        test_max();
        test_min_select();
        test_backpressure();
        test_stall();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
